rob_multi: RTL

Parametrised reorder buffer: a circular queue of in-flight instructions, allocated in program order at dispatch and retired in order at commit. Results arrive out of order on N_CDB common-data-bus ports. Two tag-indexed lookup ports serve operand forwarding to dispatch. Full and empty are derived from an occupancy counter, so the full and empty states are unambiguous. It sits between the decode/dispatch stage, the reservation stations and the register file.

---
 rtl/rob_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - reorder buffer with multi-port CDB writeback and forwarding lookups
module rob_multi #(
  parameter int W      = 16,
  parameter int N      = 3,
  parameter int OP_W   = 4,
  parameter int DEST_W = 3,
  parameter int N_CDB  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 alloc_valid,
  input  logic [DEST_W-1:0]    alloc_dest,
  input  logic [OP_W-1:0]      alloc_op,
  output logic [N-1:0]         alloc_tag,
  output logic                 alloc_ok,
  input  logic [N_CDB-1:0]     cdb_valid,
  input  logic [N_CDB*N-1:0]   cdb_tag,
  input  logic [N_CDB*W-1:0]   cdb_value,
  input  logic                 commit_en,
  output logic                 commit_valid,
  output logic [N-1:0]         commit_tag,
  output logic [DEST_W-1:0]    commit_dest,
  output logic [OP_W-1:0]      commit_op,
  output logic [W-1:0]         commit_value,
  input  logic [N-1:0]         q_tag0,
  input  logic [N-1:0]         q_tag1,
  output logic                 q_ready0,
  output logic                 q_ready1,
  output logic [W-1:0]         q_value0,
  output logic [W-1:0]         q_value1,
  output logic [N:0]           count,
  output logic                 full,
  output logic                 empty
);
  localparam int DEPTH = 2**N;
  localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  rdy;
  logic [W-1:0]      value_q [DEPTH];
  logic [DEST_W-1:0] dest_q  [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [N-1:0]      head;
  logic [N-1:0]      tail;
  logic              do_commit;
  logic [N-1:0]      qt    [2];
  logic              q_rdy [2];
  logic [W-1:0]      q_val [2];

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign alloc_ok     = alloc_valid & ~full;
  assign commit_valid = busy[head] & rdy[head];
  assign do_commit    = commit_valid & commit_en;
  assign alloc_tag    = tail;
  assign commit_tag   = head;
  assign commit_dest  = dest_q[head];
  assign commit_op    = op_q[head];
  assign commit_value = value_q[head];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy  <= '0;
      rdy   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      if (reset) begin
        for (int e = 0; e < DEPTH; e++) begin
          value_q[e] <= '0;
          dest_q[e]  <= '0;
          op_q[e]    <= '0;
        end
      end
    end else begin
      // Descending scan: the last NBA wins, so the lowest-index port takes a shared tag.
      for (int i = N_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && busy[cdb_tag[i*N +: N]]) begin
          rdy[cdb_tag[i*N +: N]]     <= 1'b1;
          value_q[cdb_tag[i*N +: N]] <= cdb_value[i*W +: W];
        end
      end
      if (alloc_ok) begin
        busy[tail]   <= 1'b1;
        rdy[tail]    <= 1'b0;
        dest_q[tail] <= alloc_dest;
        op_q[tail]   <= alloc_op;
        tail         <= tail + N'(1);
      end
      // Placed after writeback so a same-cycle writeback to the head cannot resurrect it.
      if (do_commit) begin
        busy[head] <= 1'b0;
        rdy[head]  <= 1'b0;
        head       <= head + N'(1);
      end
      case ({alloc_ok, do_commit})
        2'b10:   count <= count + (N+1)'(1);
        2'b01:   count <= count - (N+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign qt[0] = q_tag0;
  assign qt[1] = q_tag1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_rdy[p] = busy[qt[p]] & rdy[qt[p]];
      q_val[p] = value_q[qt[p]];
      for (int i = N_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*N +: N] == qt[p]) && busy[qt[p]]) begin
          q_rdy[p] = 1'b1;
          q_val[p] = cdb_value[i*W +: W];
        end
      end
    end
  end

  assign q_ready0 = q_rdy[0];
  assign q_ready1 = q_rdy[1];
  assign q_value0 = q_val[0];
  assign q_value1 = q_val[1];
endmodule
